// File: rtl/carregador_matrizes.sv
// carregador_matrizes: packs a row-major byte stream into two flattened
// DIM x DIM operands and holds them stable for the downstream multiplier.
module carregador_matrizes #(
  parameter int ELEM_W      = 8,
  parameter int DIM         = 5,
  parameter int HOLD_CICLOS = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      iniciar,
  input  logic [7:0]                tamanho,
  input  logic [ELEM_W-1:0]         dado,
  input  logic                      dado_valido,
  output logic                      dado_pronto,
  output logic [ELEM_W*DIM*DIM-1:0] matriz_a,
  output logic [ELEM_W*DIM*DIM-1:0] matriz_b,
  output logic [7:0]                tamanho_out,
  output logic                      matrizes_validas,
  output logic                      carga_concluida,
  output logic                      erro_tamanho
);

  localparam int MW = ELEM_W * DIM * DIM;
  localparam int AW = $clog2(MW);
  localparam int HW = $clog2(HOLD_CICLOS + 1);

  typedef enum logic [1:0] {
    OCIOSO,
    CARGA_A,
    CARGA_B,
    ESPERA
  } estado_t;

  estado_t       estado;
  logic [7:0]    linha;
  logic [7:0]    coluna;
  logic [HW-1:0] espera;
  logic [AW-1:0] base;
  logic          xfer;
  logic          fim_col;
  logic          fim_lin;
  logic          tam_ok;

  assign dado_pronto = (estado == CARGA_A) || (estado == CARGA_B);
  assign xfer        = dado_valido && dado_pronto;
  assign fim_col     = coluna == tamanho_out - 8'd1;
  assign fim_lin     = linha == tamanho_out - 8'd1;
  assign tam_ok      = (tamanho != 8'd0) && (tamanho <= 8'(DIM));

  // Row stride is always DIM, so small matrices leave the padding at zero.
  assign base = AW'(ELEM_W * (int'(coluna) + DIM * int'(linha)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado           <= OCIOSO;
      linha            <= '0;
      coluna           <= '0;
      espera           <= '0;
      matriz_a         <= '0;
      matriz_b         <= '0;
      tamanho_out      <= '0;
      matrizes_validas <= 1'b0;
      carga_concluida  <= 1'b0;
      erro_tamanho     <= 1'b0;
    end else begin
      erro_tamanho <= 1'b0;
      unique case (estado)
        OCIOSO: begin
          if (iniciar) begin
            if (tam_ok) begin
              tamanho_out <= tamanho;
              matriz_a    <= '0;
              matriz_b    <= '0;
              linha       <= '0;
              coluna      <= '0;
              estado      <= CARGA_A;
            end else begin
              erro_tamanho <= 1'b1;
            end
          end
        end
        CARGA_A, CARGA_B: begin
          if (xfer) begin
            if (estado == CARGA_A) begin
              matriz_a[base +: ELEM_W] <= dado;
            end else begin
              matriz_b[base +: ELEM_W] <= dado;
            end
            if (fim_col) begin
              coluna <= '0;
              linha  <= linha + 8'd1;
            end else begin
              coluna <= coluna + 8'd1;
            end
            if (fim_col && fim_lin) begin
              linha <= '0;
              if (estado == CARGA_A) begin
                estado <= CARGA_B;
              end else begin
                estado           <= ESPERA;
                matrizes_validas <= 1'b1;
                espera           <= HW'(1);
                carga_concluida  <= (HOLD_CICLOS == 1);
              end
            end
          end
        end
        ESPERA: begin
          if (espera == HW'(HOLD_CICLOS)) begin
            estado           <= OCIOSO;
            matrizes_validas <= 1'b0;
            carga_concluida  <= 1'b0;
            espera           <= '0;
          end else begin
            espera          <= espera + HW'(1);
            carga_concluida <= (espera == HW'(HOLD_CICLOS - 1));
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: doc/carregador_matrizes.md
Name: carregador_matrizes

Overview:
- Upstream stage of the 5x5 matrix multiplier.
- Accepts a byte stream of signed 8-bit elements (row-major, matrix A then matrix B) over a valid/ready handshake.
- Assembles the elements into two flattened 200-bit operand registers, zero-padding anything outside tamanho x tamanho.
- Holds both operands stable for a fixed window so the multiplier can sweep all five result rows.

Parameters:
- ELEM_W, 8, element width in bits
- DIM, 5, maximum matrix dimension; the flattened width is ELEM_W*DIM*DIM
- HOLD_CICLOS, 5, number of cycles the operands are held valid after loading; must be >= DIM

Ports:
- clk  input  1  system clock; all logic is on the rising edge
- rst_n  input  1  synchronous reset, active-low
- iniciar  input  1  start-load request; sampled only in state OCIOSO
- tamanho  input  8  matrix dimension; sampled when iniciar is accepted
- dado  input  8  signed element data
- dado_valido  input  1  dado is valid this cycle
- dado_pronto  output  1  loader accepts an element this cycle
- matriz_a  output  200  flattened matrix A; element (l,c) at bits [8*(c+5*l) +: 8]
- matriz_b  output  200  flattened matrix B, same layout as matriz_a
- tamanho_out  output  8  latched dimension
- matrizes_validas  output  1  high while the operands are held stable for the consumer
- carga_concluida  output  1  one-cycle pulse at the end of the hold window
- erro_tamanho  output  1  one-cycle pulse when iniciar arrives with an illegal tamanho

Behaviour:
- Interface: one clock, clk. Reset is rst_n, synchronous and active-low.
- Reset values (rst_n=0 at a clock edge):
  - all outputs 0
  - state OCIOSO
  - linha=0, coluna=0, hold counter=0
  - reset mid-load or mid-hold aborts immediately; partial data is discarded.
- States: OCIOSO, CARGA_A, CARGA_B, ESPERA.
- OCIOSO:
  - dado_pronto=0.
  - iniciar=1 with tamanho in 1..DIM:
    - latch tamanho into tamanho_out
    - clear matriz_a and matriz_b to 0
    - linha=coluna=0
    - next state CARGA_A
  - iniciar=1 with tamanho=0 or >DIM: erro_tamanho=1 for one cycle, stay in OCIOSO, matrices and tamanho_out unchanged.
- CARGA_A / CARGA_B:
  - dado_pronto=1 combinationally in both states.
  - Transfer happens when dado_valido && dado_pronto; write dado at index (linha,coluna) of the current matrix.
  - After a transfer, coluna increments. When coluna==tamanho-1, coluna wraps to 0 and linha increments.
  - No transfer: counters and matrices hold; dado_valido may toggle freely.
  - Last element of A (linha=coluna=tamanho-1): counters reset, next state CARGA_B. No bubble: dado_pronto stays 1 and the next cycle accepts B(0,0).
  - Last element of B: next state ESPERA; dado_pronto drops to 0 the following cycle.
  - iniciar is ignored in every state except OCIOSO.
- ESPERA:
  - matrizes_validas=1 for exactly HOLD_CICLOS consecutive cycles; matriz_a, matriz_b and tamanho_out are held constant.
  - On the last hold cycle, carga_concluida=1 (coincident with the final matrizes_validas=1 cycle); next state OCIOSO.
- After returning to OCIOSO, matriz_a, matriz_b and tamanho_out keep their values until the next accepted iniciar clears them.
- Latency: first matrizes_validas=1 occurs one cycle after the final B transfer.
- Minimum load time is 2*tamanho^2 accepted transfers.
- Width and packing rules:
  - Elements are stored verbatim as 8-bit two's complement; no arithmetic is performed in this block.
  - Positions with linha>=tamanho or coluna>=tamanho stay 0.

Test Plan:
- Reset then iniciar with tamanho=5; stream A=1..25 and B=identity, dado_valido held 1 -> 50 transfers in 50 cycles; matriz_a[7:0]=1, matriz_a[199:192]=25; matriz_b diagonal bytes=1, all others 0; matrizes_validas high for 5 cycles; carga_concluida pulses on the 5th of those cycles.
- tamanho=2, stream A={1,2,3,4}, B={-1,-2,-3,-4} -> matriz_a bits [7:0]=1, [15:8]=2, [47:40]=3, [55:48]=4; matriz_b equivalent bytes 0xFF, 0xFE, 0xFD, 0xFC; all other bytes 0; tamanho_out=2.
- tamanho=3 with dado_valido toggling every other cycle -> exactly 18 transfers; no element skipped or duplicated; matrix contents identical to the gap-free run.
- iniciar with tamanho=0, then with tamanho=6 -> erro_tamanho pulses once each time; dado_pronto stays 0; previous matrices unchanged.
- rst_n low for one cycle after the 7th A transfer -> next cycle all outputs 0 and state OCIOSO; a fresh tamanho=5 load then completes correctly.
- iniciar pulsed during CARGA_B and during ESPERA -> ignored; load and hold timing unchanged.
